// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline stage register with valid/ready
// handshaking, stall hold, synchronous flush and an optional 2-entry skid
// buffer. Sits at every stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
//
// Ports:
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   flush          synchronous clear; drops held entries and any same-cycle input
//   stall          freeze: no accept, no release, out_valid/in_ready forced low
//   in_valid/in_data/in_ready     upstream handshake (WIDTH-bit payload)
//   out_valid/out_data/out_ready  downstream handshake; out_data = NOP_VALUE when empty
//   occupancy      entries held (0..1 with SKID=0, 0..2 with SKID=1)
//   flush_drops    saturating count of valid entries discarded by flush
module pipe_stage_reg #(
    parameter int unsigned      WIDTH     = 64,
    parameter int unsigned      SKID      = 0,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0,
    parameter int unsigned      CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             stall,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] flush_drops
);

    // Encoding equals the number of held entries, so occupancy is the state.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic [CNT_W-1:0] drops_q, drops_d;

    logic             accept;
    logic             rel;
    logic [CNT_W+1:0] drops_sum;

    // Outputs. in_ready is held low while reset is asserted; state_q is
    // already EMPTY then, so the remaining outputs follow asynchronously.
    always_comb begin
        if (SKID != 0) begin
            // Depends only on registered state: no path from out_ready.
            in_ready = rst_n & ~stall & (state_q != ST_TWO);
        end else begin
            // Full throughput: a full stage accepts when the head leaves.
            in_ready = rst_n & ~stall & ((state_q == ST_EMPTY) | out_ready);
        end
        out_valid   = ~stall & (state_q != ST_EMPTY);
        out_data    = (state_q == ST_EMPTY) ? NOP_VALUE : head_q;
        occupancy   = state_q;
        flush_drops = drops_q;
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        drops_d = drops_q;

        // Flush overrides both handshakes.
        accept = in_valid & in_ready & ~flush;
        rel    = out_valid & out_ready & ~flush;

        // Two guard bits make overflow of the add visible for saturation.
        drops_sum = {2'b00, drops_q} + {{CNT_W{1'b0}}, occupancy};

        if (flush) begin
            state_d = ST_EMPTY;
            if (drops_sum[CNT_W+1:CNT_W] != 2'b00) begin
                drops_d = '1;
            end else begin
                drops_d = drops_sum[CNT_W-1:0];
            end
        end else begin
            // Stall needs no branch here: it already masks accept and rel.
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        head_d  = in_data;
                    end
                end
                ST_ONE: begin
                    if (accept && rel) begin
                        head_d = in_data;
                    end else if (accept) begin
                        // Only reachable with the skid buffer present.
                        if (SKID != 0) begin
                            state_d = ST_TWO;
                            skid_d  = in_data;
                        end
                    end else if (rel) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (rel) begin
                        state_d = ST_ONE;
                        head_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            head_q  <= NOP_VALUE;
            skid_q  <= NOP_VALUE;
            drops_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
            drops_q <= drops_d;
        end
    end

endmodule
